// File: rtl/mc_state_seq.sv
// mc_state_seq: multicycle main-state sequencer for the ARM controller.
// Moore machine. Every datapath select and write strobe is decoded from the
// current state, with MemReady gating only the FETCH and MEMWRITE strobes.
// Downstream condition logic qualifies RegW/MemW/NextPC/Branch. Holding
// reset low blanks all decoded outputs, so no strobe leaks out of a reset
// cycle.
module mc_state_seq #(
    parameter bit FAULT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       Retire,
    output logic       Fault,
    output logic [3:0] StateDbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd15
    } state_t;

    // Datapath selects and strobes, decoded together per state.
    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       retire;
        logic       fault;
    } ctrl_t;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_RDATA   = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;

    // Funct[4:1] only matter to the ALU decoder, not to sequencing.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // State register: synchronous active-low reset returns to FETCH.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    // Next-state: only FETCH, MEMREAD and MEMWRITE wait on MemReady.
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:    state_nxt = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_nxt = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_nxt = S_MEMADR;
                    2'b10:   state_nxt = S_BRANCH;
                    default: state_nxt = S_FAULT;
                endcase
            end
            S_MEMADR:   state_nxt = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nxt = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_nxt = S_ALUWB;
            S_EXECUTEI: state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_FAULT:    state_nxt = FAULT_STICKY ? S_FAULT : S_FETCH;
            // Codes 10-14 are unreachable; recover through FETCH.
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Output decode: everything defaults to 0, blanked while reset is low.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.adrsrc    = 1'b0;
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURES;
                ctrl.irwrite   = MemReady;
                ctrl.nextpc    = MemReady;
            end
            S_DECODE: begin
                // PC+4 is computed again so it is available as R15 (PC+8).
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURES;
            end
            S_MEMADR: begin
                ctrl.alusrca = SRCA_RD1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.resultsrc = RES_RDATA;
                ctrl.regw      = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_MEMWRITE: begin
                // The write is held until memory accepts it; the instruction
                // retires only in the accepting cycle.
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.memw      = 1'b1;
                ctrl.retire    = MemReady;
            end
            S_EXECUTER: begin
                ctrl.alusrca = SRCA_RD1;
                ctrl.alusrcb = SRCB_RD2;
                ctrl.aluop   = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl.alusrca = SRCA_RD1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = 1'b1;
            end
            S_ALUWB: begin
                // Flag-only ops still assert RegW here; NoWrite kills it later.
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.regw      = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca   = SRCA_ALUOUT;
                ctrl.alusrcb   = SRCB_IMM;
                ctrl.resultsrc = RES_ALURES;
                ctrl.branch    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_FAULT: begin
                ctrl.fault = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (!reset)
            ctrl = '0;
    end

    assign IRWrite   = ctrl.irwrite;
    assign AdrSrc    = ctrl.adrsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign ResultSrc = ctrl.resultsrc;
    assign NextPC    = ctrl.nextpc;
    assign RegW      = ctrl.regw;
    assign MemW      = ctrl.memw;
    assign Branch    = ctrl.branch;
    assign ALUOp     = ctrl.aluop;
    assign Retire    = ctrl.retire;
    assign Fault     = ctrl.fault;
    assign StateDbg  = state;

endmodule

// File: tb/tb_mc_state_seq.sv
// tb_mc_state_seq: instruction-level reference model for mc_state_seq.
// Each instruction is expanded into its list of visited steps when it starts.
// A cursor walks that list, waiting on MemReady at the memory-facing steps.
// Expected outputs come from a per-step table. Per-instruction latency is
// also checked against the published cycle counts plus wait cycles.
module tb_mc_state_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic       MemReady = 1'b1;
    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Retire, Fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] StateDbg;
    logic [14:0] dut_o;

    int checks = 0;
    int failures = 0;

    // model state
    int plan[$];
    int idx = 0;
    int cur = -1;
    int base = 0;
    int ncyc = 0;
    int nwait = 0;
    bit rand_mode = 1'b0;
    logic [1:0] q_op[$];
    logic [5:0] q_fn[$];

    mc_state_seq #(.FAULT_STICKY(1'b1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .Branch(Branch), .ALUOp(ALUOp), .Retire(Retire), .Fault(Fault),
        .StateDbg(StateDbg)
    );

    assign dut_o = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                    NextPC, RegW, MemW, Branch, ALUOp, Retire, Fault};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for a step, written straight from the per-state table.
    function automatic logic [14:0] exp_out(input int s, input logic mr, input logic rst);
        logic irw, adr, npc, rw, mw, br, aop, ret, flt;
        logic [1:0] sa, sb, rs;
        {irw, adr, npc, rw, mw, br, aop, ret, flt} = '0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00;
        if (rst) begin
            case (s)
                0: begin irw = mr; npc = mr; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
                1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
                2: begin sb = 2'b01; end
                3: begin adr = 1'b1; end
                4: begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
                5: begin adr = 1'b1; mw = 1'b1; ret = mr; end
                6: begin aop = 1'b1; end
                7: begin sb = 2'b01; aop = 1'b1; end
                8: begin rw = 1'b1; ret = 1'b1; end
                9: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1'b1; ret = 1'b1; end
                15: begin flt = 1'b1; end
                default: ;
            endcase
        end
        return {irw, adr, sa, sb, rs, npc, rw, mw, br, aop, ret, flt};
    endfunction

    task automatic restart();
        idx = 0; cur = 0; ncyc = 0; nwait = 0;
    endtask

    // Pick the next instruction and expand it into its step list.
    task automatic new_instr();
        logic [1:0] o;
        logic [5:0] f;
        int r;
        if (q_op.size() > 0) begin
            o = q_op.pop_front();
            f = q_fn.pop_front();
        end else if (rand_mode) begin
            r = $urandom_range(0, 15);
            o = (r == 0) ? 2'd3 : 2'(r % 3);
            f = 6'($urandom);
        end else begin
            o = 2'b00;
            f = 6'd0;
        end
        Op = o;
        Funct = f;
        case (o)
            2'b00: begin plan = f[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8}; base = 4; end
            2'b01: begin
                if (f[0]) begin plan = '{0, 1, 2, 3, 4}; base = 5; end
                else      begin plan = '{0, 1, 2, 5};    base = 4; end
            end
            2'b10: begin plan = '{0, 1, 9}; base = 3; end
            default: begin plan = '{0, 1, 15}; base = 0; end
        endcase
        restart();
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge(input logic rst, input logic mr);
        if (!rst) begin
            // Reset restarts the held instruction; a faulting one is replaced.
            if (plan.size() == 0 || Op == 2'b11) new_instr();
            else restart();
            return;
        end
        ncyc++;
        if ((cur == 0 || cur == 3 || cur == 5) && !mr) begin
            nwait++;
        end else if (idx == plan.size() - 1) begin
            if (cur != 15) begin
                chk("latency", 32'(ncyc), 32'(base + nwait));
                new_instr();
            end
        end else begin
            idx++;
            cur = plan[idx];
        end
    endtask

    task automatic cyc(input logic r, input logic m);
        reset = r;
        MemReady = m;
        #1;
        chk("outs", 32'(dut_o), 32'(exp_out(cur, m, r)));
        if (cur >= 0) chk("state", 32'(StateDbg), 32'(cur));
        @(posedge clk);
        model_edge(r, m);
        @(negedge clk);
    endtask

    task automatic run_until(input int code);
        int n;
        n = 0;
        while (cur != code && n < 40) begin
            cyc(1'b1, 1'b1);
            n++;
        end
        chk("reach", 32'(StateDbg), 32'(code));
    endtask

    task automatic push(input logic [1:0] o, input logic [5:0] f);
        q_op.push_back(o);
        q_fn.push_back(f);
    endtask

    initial begin
        push(2'b00, 6'b100000);  // DP immediate
        push(2'b01, 6'b011001);  // LDR
        push(2'b01, 6'b011000);  // STR
        push(2'b10, 6'b000000);  // B
        push(2'b00, 6'b001000);  // DP register
        push(2'b01, 6'b011001);  // LDR with read waits
        push(2'b01, 6'b011000);  // STR with write waits
        push(2'b01, 6'b011000);  // STR interrupted by reset
        push(2'b11, 6'b000000);  // illegal op -> FAULT
        #2;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        repeat (20) cyc(1'b1, 1'b1);

        run_until(3);
        repeat (3) cyc(1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b1);

        run_until(5);
        repeat (2) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);

        run_until(5);
        repeat (2) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0);
        run_until(5);
        cyc(1'b1, 1'b1);

        run_until(15);
        repeat (10) cyc(1'b1, 1'($urandom));
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);

        rand_mode = 1'b1;
        repeat (3000)
            cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
